// File: rtl/sprite_dma_ctrl.sv
// rtl/sprite_dma_ctrl.sv - sprite-list DMA sequencer
// DMA_ON arms a copy of WORDS words from sprite RAM into the object buffer at the next VBLANK rise.
module sprite_dma_ctrl #(
  parameter int WORDS = 512,
  parameter int AW    = 9,
  parameter int DW    = 16
) (
  input  logic          CLK_32M,
  input  logic          RESET_N,
  input  logic          DMA_ON,
  input  logic          VBLANK,
  output logic          BUS_REQ,
  input  logic          BUS_ACK,
  output logic [AW-1:0] SRC_ADDR,
  output logic          SRC_RD,
  input  logic [DW-1:0] SRC_DATA,
  output logic [AW-1:0] DST_ADDR,
  output logic [DW-1:0] DST_DATA,
  output logic          DST_WE,
  output logic          BUSY,
  output logic          DONE
);
  localparam int CW = AW + 1;
  localparam logic [AW:0] END_RC  = CW'(WORDS);
  localparam logic [AW:0] LAST_WC = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, FIN} state_t;

  state_t      state;
  logic        armed;
  logic        pending;
  logic        vblank_d;
  logic [AW:0] rc;
  logic [AW:0] wc;
  logic        vblank_rise;
  logic        rd_go;

  assign vblank_rise = VBLANK & ~vblank_d;

  // Reads follow the grant combinationally so a dropped ACK stops the very next read.
  assign rd_go    = (state == XFER) && BUS_ACK && (rc < END_RC);
  assign SRC_RD   = rd_go;
  assign SRC_ADDR = rc[AW-1:0];
  assign DST_ADDR = wc[AW-1:0];
  assign DST_DATA = DST_WE ? SRC_DATA : '0;

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      armed    <= 1'b0;
      pending  <= 1'b0;
      vblank_d <= 1'b0;
      rc       <= '0;
      wc       <= '0;
      BUS_REQ  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      DST_WE   <= 1'b0;
    end else begin
      vblank_d <= VBLANK;
      DONE     <= 1'b0;
      DST_WE   <= rd_go;
      if (rd_go) rc <= rc + 1'b1;
      if (DST_WE) wc <= wc + 1'b1;

      case (state)
        IDLE: begin
          if (vblank_rise && (armed || DMA_ON)) begin
            state   <= REQ;
            armed   <= 1'b0;
            BUS_REQ <= 1'b1;
            BUSY    <= 1'b1;
          end else if (DMA_ON) begin
            armed <= 1'b1;
          end
        end
        REQ: begin
          if (DMA_ON) pending <= 1'b1;
          if (BUS_ACK) begin
            state <= XFER;
            rc    <= '0;
            wc    <= '0;
          end
        end
        XFER: begin
          if (DMA_ON) pending <= 1'b1;
          // The write that lands wc on WORDS is the last one; release the bus right after it.
          if (DST_WE && (wc == LAST_WC)) begin
            state   <= FIN;
            BUS_REQ <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
          end
        end
        FIN: begin
          state   <= IDLE;
          armed   <= pending | DMA_ON;
          pending <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sprite_dma_ctrl.md
Name: sprite_dma_ctrl

Overview:
- Sequences the sprite-list DMA that the I/O decoder's DMA_ON write strobe requests.
- A DMA_ON write arms the block. On the next VBLANK rising edge it requests the shared sprite RAM from the CPU side and copies WORDS 16-bit words into the sprite object buffer, one word per cycle while the bus is granted.
- It sits between the PAL-style I/O decode, the CPU/sprite-RAM bus arbiter and the sprite renderer's line buffer fill.

Parameters:
- WORDS, 512: number of words copied per transfer.
- AW, 9: address width of source and destination (clog2 of WORDS).
- DW, 16: data width.

Ports:
- CLK_32M  in  1  system clock.
- RESET_N  in  1  reset, asynchronous, active-low.
- DMA_ON  in  1  one-cycle pulse, I/O write decode of the DMA trigger port.
- VBLANK  in  1  vertical blank level, synchronous to CLK_32M.
- BUS_REQ  out  1  request for sprite RAM ownership.
- BUS_ACK  in  1  grant from arbiter. Level signal; may drop at any time.
- SRC_ADDR  out  AW  sprite RAM word address.
- SRC_RD  out  1  read strobe. Data is returned one cycle later.
- SRC_DATA  in  DW  read data, valid the cycle after SRC_RD.
- DST_ADDR  out  AW  object buffer word address.
- DST_DATA  out  DW  object buffer write data.
- DST_WE  out  1  object buffer write enable.
- BUSY  out  1  high from bus request until the last write.
- DONE  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; armed = 0; pending = 0; read and write counters = 0; vblank_d = 0.
  - All outputs = 0.
- VBLANK edge detection:
  - vblank_rise = VBLANK & ~vblank_d, registered each cycle.
- States:
  - IDLE: DMA_ON sets armed. Go to REQ on vblank_rise when armed is set, or when DMA_ON arrives in the same cycle as vblank_rise.
  - REQ: BUS_REQ=1, BUSY=1. On BUS_ACK=1, go to XFER. Read counter rc = 0, write counter wc = 0.
  - XFER: BUS_REQ=1.
    - Each cycle with BUS_ACK=1 and rc<WORDS: SRC_RD=1, SRC_ADDR=rc, rc++.
    - Each cycle following an SRC_RD: DST_WE=1, DST_ADDR=wc, DST_DATA=SRC_DATA, wc++.
    - Throughput is 1 word/cycle. First write occurs 1 cycle after the first read.
  - BUS_ACK drop in XFER: SRC_RD deasserts the same cycle. A read issued in the previous cycle still produces its write. Counters hold. Reads resume on the first cycle BUS_ACK returns; no word is skipped or duplicated.
  - Leaving XFER: when wc reaches WORDS, go to FIN. BUS_REQ drops in the cycle after the last write.
  - FIN: DONE=1 for one cycle, BUSY=0, armed=0.
    - If pending=1: clear pending, set armed, go to IDLE. The next vblank_rise restarts the transfer.
    - Otherwise go to IDLE.
- DMA_ON while in REQ, XFER or FIN: sets pending. It never restarts the current transfer.
- Multiple DMA_ON pulses while idle or busy collapse into a single request.
- VBLANK falling mid-transfer: ignored. The transfer always runs to WORDS.
- vblank_rise while busy: ignored.
- Counters are AW+1 bits so WORDS=2^AW terminates cleanly. Addresses use the low AW bits.
- Minimum transfer time with continuous grant: 1 cycle in REQ after the ACK, WORDS+1 cycles in XFER, then the DONE cycle.
- RESET_N low mid-transfer: BUS_REQ, SRC_RD and DST_WE go to 0 immediately. Partial buffer contents are left as-is.

Test Plan:
- Continuous grant:
  - Stimulus: DMA_ON pulse, vblank_rise 100 cycles later, BUS_ACK tied 1 when requested, SRC_DATA = address ^ 16'hA5A5.
  - Required: 512 DST_WE cycles, DST_DATA[n] = n^16'hA5A5, DONE exactly once, BUSY low afterwards.
- No trigger:
  - Stimulus: vblank_rise with no DMA_ON.
  - Required: BUS_REQ stays 0 through 3 frames.
- Grant withdrawn mid-transfer:
  - Stimulus: BUS_ACK drops for 7 cycles after word 200 is read, then returns.
  - Required: word 200 is still written, no SRC_RD during the gap, words 201..511 follow. Each address is written once.
- Trigger while busy:
  - Stimulus: DMA_ON at word 300 of a transfer.
  - Required: the current transfer completes with one DONE, the second transfer starts at the next vblank_rise, 2 DONE pulses total.
- Simultaneous events:
  - Stimulus: DMA_ON in the same cycle as vblank_rise.
  - Required: BUS_REQ=1 on the next cycle.
- Reset mid-transfer:
  - Stimulus: RESET_N asserted at word 100.
  - Required: all outputs 0 asynchronously. After release, no transfer until a new DMA_ON followed by vblank_rise.
